// File: rtl/nf10_axil_pkg.sv
// Shared types for the NF10 AXI4-Lite register master: response codes,
// FSM state encoding and the watchdog counter width.
package nf10_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int WDOG_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // States in which the transaction is waiting on the slave.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WR) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Per-transaction watchdog: cleared at command accept, counts while enabled, expire is
// combinational on the final cycle (count == C_TIMEOUT-1); C_TIMEOUT=0 never expires.
module axil_watchdog #(
  parameter int C_TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  import nf10_axil_pkg::*;

  localparam bit              LP_ACTIVE = (C_TIMEOUT != 0);
  localparam logic [WDOG_W-1:0] LP_LIMIT = LP_ACTIVE ? WDOG_W'(C_TIMEOUT - 1) : '0;

  logic [WDOG_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && LP_ACTIVE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = LP_ACTIVE && i_en && (r_cnt == LP_LIMIT);

endmodule

// File: rtl/nf10_axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one local command in, one response out; first VALID
// one cycle after accept; cmd_ready low until the response is taken; watchdog aborts stuck slaves.
module nf10_axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT          = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  import nf10_axil_pkg::*;

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  state_e          r_state;
  logic            r_cmd_ready;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_wstrb;
  logic            r_awvalid;
  logic            r_wvalid;
  logic            r_aw_done;
  logic            r_w_done;
  logic            r_bready;
  logic            r_arvalid;
  logic            r_rready;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic [1:0]      r_rsp_resp;
  logic            r_rsp_timeout;

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_wd_en;
  logic w_expire;
  logic w_progress;
  logic w_tmo;

  assign w_accept = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;
  assign w_aw_hs  = r_awvalid && M_AXI_AWREADY;
  assign w_w_hs   = r_wvalid && M_AXI_WREADY;
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done || w_w_hs;
  assign w_wd_en  = is_wait_state(r_state);

  axil_watchdog #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_wdog (
    .i_clk    (M_AXI_ACLK),
    .i_rst_n  (M_AXI_ARESETN),
    .i_clr    (w_accept),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  // The awaited handshake landing on the expiry cycle takes priority over the timeout.
  always_comb begin
    w_progress = 1'b0;
    case (r_state)
      ST_WR:      w_progress = w_aw_fin && w_w_fin;
      ST_WR_RESP: w_progress = M_AXI_BVALID;
      ST_RD_ADDR: w_progress = M_AXI_ARREADY;
      ST_RD_DATA: w_progress = M_AXI_RVALID;
      default:    w_progress = 1'b0;
    endcase
  end

  assign w_tmo = w_expire && !w_progress;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_SLVERR;
      r_rsp_timeout <= 1'b1;
      r_state       <= ST_RESP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready   <= 1'b0;
            r_addr        <= cmd_addr;
            r_wdata       <= cmd_wdata;
            r_wstrb       <= cmd_wstrb;
            r_rsp_timeout <= 1'b0;
            if (cmd_rnw) begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end else begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR;
            end
          end
        end
        ST_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= M_AXI_BRESP;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (M_AXI_RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_nf10_axi_lite_master.sv
// Bench for nf10_axi_lite_master: scoreboarded commands against an ipif_regs-like slave model.
module tb_nf10_axi_lite_master;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  nf10_axi_lite_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (32),
    .C_TIMEOUT          (TMO)
  ) dut (
    .M_AXI_ACLK (clk), .M_AXI_ARESETN (rst_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_rnw (cmd_rnw),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_resp (rsp_resp), .rsp_timeout (rsp_timeout),
    .M_AXI_AWADDR (awaddr), .M_AXI_AWVALID (awvalid), .M_AXI_AWREADY (awready),
    .M_AXI_WDATA (wdata), .M_AXI_WSTRB (wstrb), .M_AXI_WVALID (wvalid), .M_AXI_WREADY (wready),
    .M_AXI_BRESP (bresp), .M_AXI_BVALID (bvalid), .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr), .M_AXI_ARVALID (arvalid), .M_AXI_ARREADY (arready),
    .M_AXI_RDATA (rdata), .M_AXI_RRESP (rresp), .M_AXI_RVALID (rvalid), .M_AXI_RREADY (rready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] slv_mem[int unsigned];

  // slave / monitor knobs
  int aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0, hold_knob = 0;
  bit ar_block = 0, r_block = 0, allow_drop = 0, saw_split = 0;
  int cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: word memory with byte strobes; >=0x1000 decodes to nothing; 0x1C reads SLVERR.
  function automatic exp_t model(input bit rnw, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input bit tmo);
    exp_t        e;
    logic [31:0] w;
    e.rdata = 32'h0; e.resp = 2'b00; e.tmo = 1'b0;
    if (tmo) begin
      e.resp = 2'b10; e.tmo = 1'b1;
    end else if (a >= 32'h1000) begin
      e.resp = 2'b11;
    end else if (!rnw) begin
      w = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[a] = w;
    end else begin
      e.rdata = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
      e.resp  = (a == 32'h1C) ? 2'b10 : 2'b00;
    end
    return e;
  endfunction

  // Slave model, acting on falling edges; hs_* are handshakes that happen at the next rising edge.
  initial begin
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, p_aw, p_w, p_ar, aw_got, w_got, b_pend, r_pend;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [31:0] aw_a, w_d, r_a, m;
    logic [3:0]  w_s;
    logic [1:0]  b_r;
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
    {hs_aw, hs_w, hs_b, hs_ar, hs_r, p_aw, p_w, p_ar, aw_got, w_got, b_pend, r_pend} = '0;
    {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
    aw_a = 0; w_d = 0; r_a = 0; w_s = 0; b_r = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        {hs_aw, hs_w, hs_b, hs_ar, hs_r, p_aw, p_w, p_ar, aw_got, w_got, b_pend, r_pend} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        continue;
      end
      if (p_aw && !awvalid) check("awvalid_drop_legal", 32'(hs_aw | allow_drop), 32'd1);
      if (p_w  && !wvalid)  check("wvalid_drop_legal",  32'(hs_w  | allow_drop), 32'd1);
      if (p_ar && !arvalid) check("arvalid_drop_legal", 32'(hs_ar | allow_drop), 32'd1);
      if (hs_aw) begin aw_got = 1; awready = 0; end
      if (hs_w)  begin w_got  = 1; wready  = 0; end
      if (hs_b)  bvalid = 0;
      if (hs_ar) begin arready = 0; r_pend = 1; r_cnt = r_dly; end
      if (hs_r)  rvalid = 0;
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0;
        if (aw_a >= 32'h1000) b_r = 2'b11;
        else begin
          m = slv_mem.exists(aw_a) ? slv_mem[aw_a] : 32'h0;
          for (int b = 0; b < 4; b++) if (w_s[b]) m[8*b +: 8] = w_d[8*b +: 8];
          slv_mem[aw_a] = m;
          b_r = 2'b00;
        end
        b_pend = 1; b_cnt = b_dly;
      end
      if (b_pend) begin
        if (b_cnt == 0) begin bvalid = 1; bresp = b_r; b_pend = 0; end
        else b_cnt--;
      end
      if (r_pend && !r_block) begin
        if (r_cnt == 0) begin
          rvalid = 1; r_pend = 0;
          if (r_a >= 32'h1000) begin rdata = 32'h0; rresp = 2'b11; end
          else begin
            rdata = slv_mem.exists(r_a) ? slv_mem[r_a] : 32'h0;
            rresp = (r_a == 32'h1C) ? 2'b10 : 2'b00;
          end
        end else r_cnt--;
      end
      if (awvalid && !awready) begin
        if (aw_cnt >= aw_dly) begin awready = 1; aw_cnt = 0; end else aw_cnt++;
      end
      if (wvalid && !wready) begin
        if (w_cnt >= w_dly) begin wready = 1; w_cnt = 0; end else w_cnt++;
      end
      if (arvalid && !arready && !ar_block) begin
        if (ar_cnt >= 1) begin arready = 1; ar_cnt = 0; end else ar_cnt++;
      end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      if (hs_aw) begin aw_a = awaddr; aw_hs_cyc = cyc; end
      if (hs_w)  begin w_d = wdata; w_s = wstrb; w_hs_cyc = cyc; end
      if (hs_ar) r_a = araddr;
      if (awvalid && !wvalid) saw_split = 1;
      p_aw = awvalid; p_w = wvalid; p_ar = arvalid;
    end
  end

  // Response monitor: drives rsp_ready, checks held fields, pops the scoreboard on handshake.
  initial begin
    bit          in_resp;
    int          hold;
    logic [31:0] s_rdata;
    logic [2:0]  s_meta;
    exp_t        e;
    rsp_ready = 0; in_resp = 0; hold = 0; s_rdata = 0; s_meta = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin rsp_ready = 0; in_resp = 0; continue; end
      if (rsp_valid) begin
        if (!in_resp) begin
          in_resp = 1; hold = hold_knob; s_rdata = rsp_rdata; s_meta = {rsp_resp, rsp_timeout};
        end else if (!rsp_ready) begin
          check("rsp_rdata_stable", rsp_rdata, s_rdata);
          check("rsp_resp_tmo_stable", 32'({rsp_resp, rsp_timeout}), 32'(s_meta));
          check("cmd_ready_low_in_resp", 32'(cmd_ready), 32'd0);
        end
        if (hold > 0) begin rsp_ready = 0; hold--; end else rsp_ready = 1;
        if (rsp_ready) begin
          in_resp = 0;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%08h, expected none", rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
          end
        end
      end else begin
        rsp_ready = 0;
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic issue(input bit rnw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit tmo);
    int n = 0;
    cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 0;
      return;
    end
    check("accept_after_prev_rsp", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(model(rnw, a, d, s, tmo));
    @(negedge clk);
    cmd_valid = 0;
    if (rnw) check("arvalid_latency", 32'(arvalid), 32'd1);
    else     check("aw_w_valid_latency", 32'({awvalid, wvalid}), 32'd3);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst_n = 0; cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    ref_mem[32'h0] = 32'h20130415;
    slv_mem[32'h0] = 32'h20130415;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}), 32'd0);
    check("rst_regs", awaddr | wdata | 32'(wstrb) | rsp_rdata | 32'(rsp_resp), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk); @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // identifier read
    issue(1, 32'h0, 32'h0, 4'h0, 0); drain();

    // write with WREADY three cycles ahead of AWREADY, then readback
    aw_dly = 3; w_dly = 0; saw_split = 0;
    issue(0, 32'h20, 32'hDEADBEEF, 4'hF, 0); drain();
    check("w_before_aw_cycles", 32'(aw_hs_cyc - w_hs_cyc), 32'd3);
    check("aw_w_split_seen", 32'(saw_split), 32'd1);
    aw_dly = 0;
    issue(1, 32'h20, 32'h0, 4'h0, 0); drain();

    // slave error
    issue(1, 32'h1C, 32'h0, 4'h0, 0); drain();

    // missing ARREADY -> watchdog
    ar_block = 1; allow_drop = 1;
    issue(1, 32'h24, 32'h0, 4'h0, 1);
    n = 0;
    while (arvalid && n < 100) begin n++; @(negedge clk); end
    check("arvalid_high_cycles", 32'(n), 32'(TMO));
    drain();
    ar_block = 0; allow_drop = 0;
    issue(1, 32'h0, 32'h0, 4'h0, 0); drain();

    // response held off, next command waiting
    hold_knob = 5;
    issue(1, 32'h20, 32'h0, 4'h0, 0);
    issue(0, 32'h28, 32'h12345678, 4'h5, 0);
    hold_knob = 0;
    drain();

    // reset while waiting in RD_DATA
    r_block = 1;
    issue(1, 32'h20, 32'h0, 4'h0, 0);
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    check("reached_rd_data", 32'(rready), 32'd1);
    #2 rst_n = 0;
    #1;
    check("abort_outputs", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready, rsp_timeout}), 32'd0);
    check("abort_regs", araddr | rsp_rdata | 32'(rsp_resp), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk); r_block = 0;
    #2 rst_n = 1;
    @(negedge clk); @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    issue(1, 32'h28, 32'h0, 4'h0, 0); drain();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [31:0] a;
      k = int'($urandom_range(0, 11));
      a = (k == 10) ? 32'h1004 : (k == 11) ? 32'h1C : 32'h20 + 32'(4 * k);
      aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3));
      b_dly  = int'($urandom_range(0, 3)); r_dly = int'($urandom_range(0, 3));
      hold_knob = int'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
